// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender with a 2-entry skid buffer
// Modes: 00 sign-ext, 01 zero-ext, 10 upper-load, 11 branch offset (sign-ext then << BR_SHIFT).
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_neg;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_data;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_drain;
    logic             w_main_free;

    assign w_sext = OUT_W'($signed(in_imm));
    assign w_zext = OUT_W'(in_imm);

    always_comb begin
        w_ext = w_sext;
        case (in_mode)
            MODE_SEXT:   w_ext = w_sext;
            MODE_ZEXT:   w_ext = w_zext;
            MODE_UPPER:  w_ext = w_zext << (OUT_W - IN_W);
            MODE_BRANCH: w_ext = w_sext << BR_SHIFT;
            default:     w_ext = w_sext;
        endcase
    end

    // in_ready depends on registered state only, so no path from out_ready.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_drain     = r_out_valid & out_ready;
    assign w_main_free = ~r_out_valid | w_drain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_neg    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_neg    <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_out_neg    <= r_skid_data[OUT_W-1];
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_data <= w_ext;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ext;
                r_out_neg   <= w_ext[OUT_W-1];
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ext;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_neg   = r_out_neg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;
    logic        b_out_neg;

    int errors = 0;
    int checks = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .BR_SHIFT(1)) u_dut_b (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_neg(b_out_neg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send(input logic [15:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    initial begin
        logic pat [8];
        int   sent;
        int   rcvd;
        logic held;
        logic [31:0] hv;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_imm = '0; in_mode = 2'b00; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = 2'b00; b_out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_neg", out_neg, 0);
        reset = 1'b1;

        // Extension modes, back-to-back with out_ready=1
        send(16'h8001, 2'b00);
        b_in_valid = 1'b1; b_in_imm = 12'h800; b_in_mode = 2'b11;
        tick();
        check("sext_data", out_data, 32'hFFFF8001);
        check("sext_neg", out_neg, 1);
        check("sext_valid", out_valid, 1);
        check("p12_branch", b_out_data, 32'hFFFFF000);
        b_in_valid = 1'b0;
        send(16'h8001, 2'b01);
        tick();
        check("zext_data", out_data, 32'h00008001);
        check("zext_neg", out_neg, 0);
        send(16'h1234, 2'b10);
        tick();
        check("upper_data", out_data, 32'h12340000);
        send(16'hFFFE, 2'b11);
        tick();
        check("br_neg_data", out_data, 32'hFFFFFFF8);
        check("br_neg_neg", out_neg, 1);
        send(16'h0003, 2'b11);
        tick();
        check("br_pos_data", out_data, 32'h0000000C);
        in_valid = 1'b0;
        in_mode  = 2'b10;
        tick();
        check("idle_valid", out_valid, 0);

        // Backpressure: fill both entries, third item refused
        out_ready = 1'b0;
        send(16'h0001, 2'b01);
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_ready", in_ready, 1);
        send(16'h0002, 2'b01);
        tick();
        check("bp_full_ready", in_ready, 0);
        check("bp_hold_a", out_data, 32'h1);
        send(16'h0003, 2'b01);
        tick();
        check("bp_third_ready", in_ready, 0);
        check("bp_hold_a2", out_data, 32'h1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_b_data", out_data, 32'h2);
        check("bp_b_valid", out_valid, 1);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_no_third", out_valid, 0);

        // Stream of 8 with toggled out_ready
        sent = 0; rcvd = 0; held = 1'b0; hv = '0;
        for (int cyc = 0; cyc < 100 && rcvd < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_imm    = 16'(16'h0010 + sent);
            in_mode   = 2'b01;
            out_ready = pat[cyc % 8];
            #1;
            if (held) begin
                check("st_hold_valid", out_valid, 1);
                check("st_hold_data", out_data, hv);
            end
            held = out_valid & ~out_ready;
            hv   = out_data;
            if (out_valid && out_ready) begin
                check("st_data", out_data, 32'(32'h10 + rcvd));
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("st_count", rcvd, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("st_no_dup", out_valid, 0);

        // Flush with both entries full
        out_ready = 1'b0;
        send(16'h0055, 2'b01);
        tick();
        send(16'h0066, 2'b01);
        tick();
        check("fl_full", in_ready, 0);
        flush = 1'b1;
        send(16'h0077, 2'b01);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_data", out_data, 0);
        out_ready = 1'b1;
        tick();
        check("fl_empty", out_valid, 0);

        // Flush with an acceptable input in the same cycle
        out_ready = 1'b0;
        send(16'h0011, 2'b01);
        tick();
        flush = 1'b1;
        send(16'h0022, 2'b01);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl2_valid", out_valid, 0);
        tick();
        check("fl2_discard", out_valid, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(16'h00AB, 2'b01);
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_data", out_data, 0);
        check("ar_ready", in_ready, 1);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        send(16'h8000, 2'b00);
        tick();
        in_valid = 1'b0;
        check("ar_after_data", out_data, 32'hFFFF8000);
        check("ar_after_valid", out_valid, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
